key_press_pulse: RTL and testbench
==================================

Name: key_press_pulse

Overview:
- Consumer end of the input synchronizer (`synch`). Takes one synchronized, active-high push-button level and turns it into debounced events for the game FSM.
- Outputs one single-cycle pulse per physical press, plus a debounced "held" level.
- One instance per KEY on the DE1_SoC, placed between `synch` and the tic-tac-toe control logic.
- Any KEY inversion (the board keys are active-low) is done at top level, before `synch`.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable samples needed to accept a press or a release; legal range 2..65535.
- REPEAT_DELAY, 50: cycles in HELD before the first auto-repeat pulse; used only with KEY_REPEAT_EN; must be >= 1.
- REPEAT_PERIOD, 10: cycles between later auto-repeat pulses; used only with KEY_REPEAT_EN; must be >= 1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- in  input  1  synchronized button level from `synch`; 1 = pressed
- out  output  1  one-cycle press pulse
- held  output  1  debounced pressed level

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low.
- Reset (reset=0), effective immediately without waiting for clk:
  - state=IDLE, counter=0, out=0, held=0, repeat counter=0.
  - Release of reset is taken on the next clk edge.
- Counter: 16-bit, cnt. State encoding: 2 bits.
- out is registered. held is registered and equals 1 in HELD and DEB_RELEASE.
- IDLE:
  - in=1: go to DEB_PRESS, cnt<=1.
  - in=0: stay.
- DEB_PRESS:
  - in=0: go to IDLE, cnt<=0, no pulse.
  - in=1 and cnt==DEBOUNCE_CYCLES-1: go to HELD, out<=1, cnt<=0.
  - otherwise (in=1): cnt++.
- HELD:
  - in=0: go to DEB_RELEASE, cnt<=1.
  - in=1: stay.
- DEB_RELEASE:
  - in=1: return to HELD, cnt<=0, no pulse.
  - in=0 and cnt==DEBOUNCE_CYCLES-1: go to IDLE, cnt<=0.
  - otherwise (in=0): cnt++.
- Press latency:
  - If in is first sampled 1 at edge k and stays 1 through edge k+D-1 (D = DEBOUNCE_CYCLES), out is high only in the cycle after edge k+D-1.
  - held rises at that same edge.
- Release latency: held falls at edge j+D-1, where j is the first edge that samples 0 and in stays 0 from j onward.
- Pulse width: out is high for exactly one cycle per accepted press and is cleared on the following edge, whatever in does.
- Boundary: a press that starts while DEB_RELEASE is counting does not make a new pulse; the block stays in the same press.
- Reset mid-operation: any in-progress debounce and any pending pulse are dropped. If in is still 1 after reset releases, a full debounce runs again and one pulse is issued.
- Counter stays below DEBOUNCE_CYCLES, so it never wraps.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - Adds a 16-bit repeat counter, rcnt, cleared on entry to HELD from DEB_PRESS.
  - In HELD, rcnt increments each cycle.
  - When rcnt reaches REPEAT_DELAY, out<=1 and rcnt restarts. After that, out<=1 every REPEAT_PERIOD cycles.
  - rcnt freezes in DEB_RELEASE and resumes if the block returns to HELD.
  - rcnt clears in IDLE and on reset.
- Not defined:
  - No repeat logic is generated and the REPEAT_* parameters are ignored.
  - Exactly one pulse per press.

Decomposition:
- Package key_pkg holds:
  - typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_RELEASE} key_state_t;
  - localparam CNT_W=16;
  - default values of the three parameters.
- Natural sub-module: key_cycle_counter, a CNT_W-bit counter with clear, enable and terminal-count compare, with async active-low reset.
  - One instance for cnt; a second for rcnt under KEY_REPEAT_EN.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3):
- Clean press: in=0 for 3 edges, then in=1 from edge 3 for 12 edges -> out=1 only in the cycle after edge 6; held=1 from edge 6; no further pulse without the macro.
- Bounce: in sequence 1,1,0,1,1,1,1 from edge 0 -> DEB_PRESS aborts at edge 2; single out pulse after edge 6; held=1 from edge 6.
- Release glitch: in HELD, in=0 for 2 edges then 1 -> held stays 1 throughout; no pulse. Then in=0 for 4 edges -> held=0 at the 4th edge; next clean press gives exactly one pulse.
- Reset mid-press: reset=0 while in DEB_PRESS with cnt=2 -> out=0 and held=0 immediately, without a clock edge. After reset=1 with in=1 held -> pulse after 4 more edges.
- Back-to-back presses: two clean presses separated by 4 zero samples -> exactly two pulses, each 1 cycle wide.
- KEY_REPEAT_EN: in=1 held for 30 edges -> pulses at debounce acceptance, then 8 cycles later, then every 3 cycles. Total pulse count is checked against this schedule.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and defaults for the push-button debouncer (key_press_pulse).
package key_pkg;

  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_RELEASE} key_state_t;

  localparam int CNT_W = 16;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
  localparam int unsigned REPEAT_DELAY_DEF    = 50;
  localparam int unsigned REPEAT_PERIOD_DEF   = 10;

endpackage

// File: rtl/key_cycle_counter.sv
// CNT_W-bit up counter with synchronous clear (priority over enable) and
// a terminal-count flag raised when the count equals term.
module key_cycle_counter
  import key_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == term);

endmodule

// File: rtl/key_press_pulse.sv
// Debounces one synchronized button level into a one-cycle press pulse and a
// held level. Define KEY_REPEAT_EN to add auto-repeat pulses while held.
module key_press_pulse
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
)(
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out,
  output logic held
);

  localparam logic [CNT_W-1:0] DEB_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("key_press_pulse: illegal parameter value");
  end

  key_state_t state, state_nxt;
  logic       cnt_clr, cnt_en, cnt_tc;
  logic       press_acc;
  logic       rep_fire;

  // The debounce counter is always 0 in IDLE and HELD, so counting from
  // there loads the first stable sample as cnt=1.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    press_acc = 1'b0;
    case (state)
      IDLE: begin
        if (in) begin
          state_nxt = DEB_PRESS;
          cnt_en    = 1'b1;
        end
      end
      DEB_PRESS: begin
        if (!in) begin
          state_nxt = IDLE;
          cnt_clr   = 1'b1;
        end else if (cnt_tc) begin
          state_nxt = HELD;
          cnt_clr   = 1'b1;
          press_acc = 1'b1;
        end else begin
          cnt_en    = 1'b1;
        end
      end
      HELD: begin
        if (!in) begin
          state_nxt = DEB_RELEASE;
          cnt_en    = 1'b1;
        end
      end
      DEB_RELEASE: begin
        if (in) begin
          state_nxt = HELD;
          cnt_clr   = 1'b1;
        end else if (cnt_tc) begin
          state_nxt = IDLE;
          cnt_clr   = 1'b1;
        end else begin
          cnt_en    = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_clr   = 1'b1;
      end
    endcase
  end

  key_cycle_counter u_deb_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .term  (DEB_TERM),
    .tc    (cnt_tc)
  );

`ifdef KEY_REPEAT_EN
  // rcnt only advances on cycles that remain in HELD; it is frozen while a
  // release is being debounced and restarts after every repeat pulse.
  logic             rep_armed, rep_clr, rep_en, rep_tc;
  logic [CNT_W-1:0] rep_term;

  assign rep_en   = (state == HELD) && in;
  assign rep_fire = rep_en && rep_tc;
  assign rep_clr  = press_acc || (state == IDLE) || rep_fire;
  assign rep_term = rep_armed ? CNT_W'(REPEAT_PERIOD - 1) : CNT_W'(REPEAT_DELAY - 1);

  key_cycle_counter u_rep_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clr   (rep_clr),
    .en    (rep_en),
    .term  (rep_term),
    .tc    (rep_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_armed <= 1'b0;
    end else if (press_acc || state == IDLE) begin
      rep_armed <= 1'b0;
    end else if (rep_fire) begin
      rep_armed <= 1'b1;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      out   <= 1'b0;
      held  <= 1'b0;
    end else begin
      state <= state_nxt;
      out   <= press_acc | rep_fire;
      held  <= (state_nxt == HELD) || (state_nxt == DEB_RELEASE);
    end
  end

endmodule

// File: tb/tb_key_press_pulse.sv
// Bench for key_press_pulse: constant tables, directed corner sequences and
// random input checked against a run-length model of the debounce rules.
module tb_key_press_pulse;

  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 3;
`ifdef KEY_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic in    = 1'b0;
  logic out;
  logic held;

  key_press_pulse #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .out   (out),
    .held  (held)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  // Model: accepted level plus length of the current run of disagreeing samples.
  bit m_pressed, m_out;
  int m_run, m_age;
  bit m_armed;

  typedef struct {
    bit i;
    bit eo;
    bit eh;
  } vec_t;

  vec_t clean_tbl[15];
  vec_t bounce_tbl[7];

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b want %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pressed = 1'b0;
    m_out     = 1'b0;
    m_run     = 0;
    m_age     = 0;
    m_armed   = 1'b0;
  endtask

  task automatic model_edge(input bit v);
    m_out = 1'b0;
    if (v != m_pressed) begin
      m_run++;
      if (m_run == D) begin
        m_pressed = v;
        m_run     = 0;
        if (v) begin
          m_out   = 1'b1;
          m_age   = 0;
          m_armed = 1'b0;
        end
      end
    end else begin
      if (REP && v && m_run == 0) begin
        m_age++;
        if (m_age == (m_armed ? RP : RD)) begin
          m_out   = 1'b1;
          m_age   = 0;
          m_armed = 1'b1;
        end
      end
      m_run = 0;
    end
  endtask

  task automatic step(input bit v, input string tag);
    in = v;
    @(posedge clk);
    model_edge(v);
    #1;
    check({tag, " out"}, out, m_out);
    check({tag, " held"}, held, m_pressed);
    if (out === 1'b1) pulses++;
  endtask

  task automatic idle_n(input int n, input string tag);
    for (int k = 0; k < n; k++) step(1'b0, tag);
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check({tag, " rst out"}, out, 1'b0);
    check({tag, " rst held"}, held, 1'b0);
    #1 reset = 1'b1;
  endtask

  initial begin
    bit bseq[7];
    bit lvl;
    int runlen;

    bseq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int e = 0; e < 15; e++) begin
      clean_tbl[e].i  = (e >= 3);
      clean_tbl[e].eo = (e == 6) || (REP && e == 14);
      clean_tbl[e].eh = (e >= 6);
    end
    for (int e = 0; e < 7; e++) begin
      bounce_tbl[e].i  = bseq[e];
      bounce_tbl[e].eo = (e == 6);
      bounce_tbl[e].eh = (e == 6);
    end

    // Asynchronous reset with no clock edge
    model_reset();
    #1 reset = 1'b0;
    #1;
    check("por out", out, 1'b0);
    check("por held", held, 1'b0);
    @(posedge clk);
    #1;
    check("por held edge", held, 1'b0);
    reset = 1'b1;

    // Clean press
    for (int e = 0; e < 15; e++) begin
      step(clean_tbl[e].i, "clean");
      check("clean tbl out", out, clean_tbl[e].eo);
      check("clean tbl held", held, clean_tbl[e].eh);
    end
    idle_n(4, "release");
    check("release held", held, 1'b0);

    // Bounce during press debounce
    for (int e = 0; e < 7; e++) begin
      step(bounce_tbl[e].i, "bounce");
      check("bounce tbl out", out, bounce_tbl[e].eo);
      if (e == 6) check("bounce tbl held", held, bounce_tbl[e].eh);
    end

    // Release glitch keeps the same press
    pulses = 0;
    step(1'b0, "glitch");
    check("glitch held0", held, 1'b1);
    step(1'b0, "glitch");
    check("glitch held1", held, 1'b1);
    step(1'b1, "glitch");
    check("glitch held2", held, 1'b1);
    check_int("glitch pulses", pulses, 0);
    step(1'b0, "rel");
    step(1'b0, "rel");
    step(1'b0, "rel");
    check("rel held 3rd", held, 1'b1);
    step(1'b0, "rel");
    check("rel held 4th", held, 1'b0);
    pulses = 0;
    for (int k = 0; k < 6; k++) step(1'b1, "repress");
    check_int("repress pulses", pulses, 1);

    // Reset while held
    async_reset("held");
    in = 1'b0;
    idle_n(2, "post held rst");

    // Reset mid-press with cnt=2, then full debounce again
    step(1'b1, "midpress");
    step(1'b1, "midpress");
    async_reset("midpress");
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, "after rst");
      check("after rst out", out, (k == 3));
    end
    check_int("after rst pulses", pulses, 1);
    idle_n(4, "release2");

    // Back-to-back presses
    pulses = 0;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 5; k++) step(1'b1, "b2b");
      idle_n(4, "b2b gap");
    end
    check_int("b2b pulses", pulses, 2);

    // Long hold: auto-repeat schedule when enabled
    pulses = 0;
    for (int k = 0; k < 30; k++) step(1'b1, "long");
    check_int("long pulses", pulses, REP ? 8 : 1);
    idle_n(4, "release3");

    // Random runs with occasional asynchronous reset
    lvl = 1'b0;
    for (int n = 0; n < 150; n++) begin
      lvl = ~lvl;
      runlen = (($urandom_range(0, 3) == 0) ? $urandom_range(D, 14) : $urandom_range(1, D));
      for (int k = 0; k < runlen; k++) step(lvl, "rand");
      if ($urandom_range(0, 30) == 0) async_reset("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
